mul_datapath: RTL
=================

# mul_datapath

Datapath for the sequential repeated-addition multiplier: operand register A, down-counter B, accumulator P and the zero detector. It sits directly downstream of the multiplier controller FSM. It consumes the controller's registered strobes (lda, ldb, clrp, ldp, decb) and returns eqz to it. Operands arrive one at a time on a shared input bus, and the product is held on `product` until the next clear.

## Interface
Parameters:
- WIDTH, 16: operand width of A, B and data_in.
- PW, 16: accumulator/product width; PW >= WIDTH, and PW = 2*WIDTH gives an overflow-free product.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock, shared with the controller.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  WIDTH  shared operand bus.
- lda  in  1  load A from data_in.
- ldb  in  1  load B from data_in.
- decb  in  1  decrement B.
- clrp  in  1  clear P.
- ldp  in  1  accumulate, P <= P + A.
- eqz  out  1  B == 0, combinational from the B register.
- product  out  PW  current P register.
- ovf  out  1  sticky accumulate overflow; exists only with MUL_OVF_EN.

## Operation
- Registers: A[WIDTH], B[WIDTH], P[PW]. All update on the rising edge of clk.
- A:
  - lda=1: A <= data_in.
  - otherwise A holds.
- B:
  - ldb=1: B <= data_in. ldb has priority over decb.
  - else decb=1 and B!=0: B <= B-1.
  - else B holds.
  - B never wraps below 0.
- P:
  - clrp=1: P <= 0. clrp has priority over ldp.
  - else ldp=1 and B!=0: P <= P + zero-extended A, truncated to PW bits.
  - else P holds.
- Zero-guard: ldp and decb have no effect when B==0, using the B value sampled at the edge. Because the controller's outputs are registered, it issues one trailing ldp/decb pulse after eqz rises; the guard makes that pulse harmless. It also makes B==0 at load give product 0.
- eqz = (B == 0). It is not registered, and is valid in the same cycle B changes.
- Adder input uses A as held before the edge. lda and ldp in the same cycle accumulate the old A.
- Result: after the controller sequence (lda, then clrp+ldb, then ldp/decb until eqz), product = (A*B) mod 2^PW.

## Timing
- Reset (rst_n=0, asynchronous): A=0, B=0, P=0, ovf=0; hence eqz=1 and product=0.
  - Release is synchronous to the next clk edge.
  - Reset mid-accumulate abandons the operation and all registers return to the reset values.
- Load latency:
  - data_in is sampled at the edge where lda/ldb=1.
  - The new A/B is visible one cycle later.
  - eqz reflects a loaded B in that same following cycle.
- Accumulate: one addition per cycle with ldp=1 and B!=0. Product for multiplier n is final n cycles after the first qualified ldp.
- product is stable from the cycle eqz rises until the next clrp or reset.
- Control strobes are active-high, level-sampled, one-cycle each. No handshake beyond eqz.

## Configuration
- MUL_OVF_EN defined:
  - ovf port and sticky flag exist.
  - ovf <= 1 on any qualified accumulate whose (PW+1)-bit sum carries out of bit PW-1.
  - ovf is cleared only by clrp or reset. clrp and a carry in the same cycle: clrp wins (ovf=0).
- MUL_OVF_EN undefined:
  - No ovf port and no carry logic. The sum is truncated silently.

## Test plan
- WIDTH=16, PW=16: lda with data_in=7, then clrp+ldb with 5, then ldp+decb held → five qualified adds, product=35, eqz=1. A sixth trailing pulse leaves product=35 and B=0.
- Load B=0 (ldb with data_in=0) → eqz=1 on the next cycle. Subsequent ldp/decb pulses leave product=0 and B=0.
- clrp and ldp in the same cycle with P=35 → P=0 next cycle. ldb=3 with decb in the same cycle → B=3.
- Same-cycle lda=9 and ldp with A=4, B=2, P=0 → P=4 and A=9. The next ldp gives P=13.
- MUL_OVF_EN, WIDTH=8, PW=8: A=200, B=2 → first add P=200 with ovf=0, second add P=144 with ovf=1. ovf holds until clrp, then clears.
- Assert rst_n=0 asynchronously mid-accumulate (B=3, P=14) → A=B=P=0, eqz=1, ovf=0 immediately without a clock edge. Registers stay reset until the first edge after release.

Source files
------------

// File: rtl/mul_datapath_if.sv
// Operand bus, control strobes and result of the repeated-addition multiplier datapath.
// The ovf signal exists only when MUL_OVF_EN is defined.
interface mul_datapath_if #(
    parameter int WIDTH = 16,
    parameter int PW    = 16
);
    logic [WIDTH-1:0] data_in;
    logic             lda;
    logic             ldb;
    logic             decb;
    logic             clrp;
    logic             ldp;
    logic             eqz;
    logic [PW-1:0]    product;
`ifdef MUL_OVF_EN
    logic             ovf;

    modport master (output data_in, lda, ldb, decb, clrp, ldp,
                    input  eqz, product, ovf);
    modport slave  (input  data_in, lda, ldb, decb, clrp, ldp,
                    output eqz, product, ovf);
`else
    modport master (output data_in, lda, ldb, decb, clrp, ldp,
                    input  eqz, product);
    modport slave  (input  data_in, lda, ldb, decb, clrp, ldp,
                    output eqz, product);
`endif
endinterface

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: operand A, down-counter B, accumulator P, zero detect.
// Define MUL_OVF_EN to add the sticky accumulate-overflow flag.
module mul_datapath #(
    parameter int WIDTH = 16,
    parameter int PW    = 16
) (
    input logic           clk,
    input logic           rst_n,
    mul_datapath_if.slave bus
);
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_p;
    logic             w_b_zero;
    logic             w_acc_en;
    logic             w_dec_en;

    // Zero-guard: the trailing ldp/decb pulse issued after eqz rises is absorbed here.
    assign w_b_zero = (r_b == '0);
    assign w_acc_en = bus.ldp  && !w_b_zero;
    assign w_dec_en = bus.decb && !w_b_zero;

`ifdef MUL_OVF_EN
    logic [PW:0] w_sum;
    logic        r_ovf;

    assign w_sum = {1'b0, r_p} + (PW+1)'(r_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (bus.clrp) begin
            r_ovf <= 1'b0;
        end else if (w_acc_en && w_sum[PW]) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    logic [PW-1:0] w_sum;

    assign w_sum = r_p + PW'(r_a);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_p <= '0;
        end else begin
            if (bus.lda) begin
                r_a <= bus.data_in;
            end

            if (bus.ldb) begin
                r_b <= bus.data_in;
            end else if (w_dec_en) begin
                r_b <= r_b - WIDTH'(1);
            end

            // The adder sees A from before this edge, so lda+ldp accumulates the old operand.
            if (bus.clrp) begin
                r_p <= '0;
            end else if (w_acc_en) begin
                r_p <= w_sum[PW-1:0];
            end
        end
    end

    assign bus.eqz     = w_b_zero;
    assign bus.product = r_p;
endmodule
